// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage req/ack access controller with stall and timeout
//
// Purpose: turns the EX/MEM load/store control, address and store data into a
// single req/ack transaction on a variable-latency data memory. The pipeline is
// stalled until the transaction completes, then load data is handed to MEM/WB
// with a one-cycle valid pulse.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   MemRead, MemWrite     EX/MEM access type (both set = write)
//   ALUOut, ReadValue     EX/MEM word address and store data
//   mem_rdata, mem_ack    memory read data and completion
//   mem_req, mem_we       memory request and direction
//   mem_addr, mem_wdata   registered address and store data
//   stall                 freeze IF..EX/MEM (combinational)
//   mem_data_out          last captured load data
//   mem_valid             one-cycle completion pulse
//   err                   sticky timeout flag
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] ALUOut,
    input  logic [15:0] ReadValue,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        stall,
    output logic [15:0] mem_data_out,
    output logic        mem_valid,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               r_we;
    logic [15:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_data_out;
    logic               r_err;
    logic               w_access;
    logic               w_timeout;

    assign w_access  = MemRead | MemWrite;

    // wait_cnt is 0 in the first REQ cycle, so TIMEOUT-1 marks the last allowed cycle
    assign w_timeout = (TIMEOUT != 0) && !mem_ack &&
                       (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mem_req/stall/mem_valid decode straight from state so reset drops them at once
    always_comb begin
        w_next    = r_state;
        mem_req   = 1'b0;
        stall     = 1'b0;
        mem_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_access;
                if (w_access) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_req = 1'b1;
                stall   = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                mem_valid = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_we       <= 1'b0;
            r_addr     <= 16'h0000;
            r_wdata    <= 16'h0000;
            r_data_out <= 16'h0000;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr     <= ALUOut;
                        r_wdata    <= ReadValue;
                        r_we       <= MemWrite;
                        r_wait_cnt <= '0;
                    end
                end
                S_REQ: begin
                    r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_data_out <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_data_out = r_data_out;
    assign err          = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite;
    logic [15:0] ALUOut, ReadValue, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, mem_valid, err;
    logic [15:0] mem_addr, mem_wdata, mem_data_out;

    int npass = 0;
    int nfail = 0;

    // transaction-level reference state
    logic [15:0] exp_data;
    logic        exp_err;

    mem_access_unit #(.TIMEOUT(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .ALUOut(ALUOut), .ReadValue(ReadValue),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .mem_data_out(mem_data_out),
        .mem_valid(mem_valid), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert (obs === exp) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Non-memory cycles, optionally with stray acks that must be ignored.
    task automatic idle_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            ALUOut    = 16'($urandom);
            ReadValue = 16'($urandom);
            mem_ack   = noise ? 1'($urandom) : 1'b0;
            mem_rdata = 16'($urandom);
            #1;
            check("idle_stall", {15'd0, stall}, 16'd0);
            check("idle_req", {15'd0, mem_req}, 16'd0);
            check("idle_valid", {15'd0, mem_valid}, 16'd0);
        end
    endtask

    // One instruction starting in IDLE. k = REQ cycle carrying the ack, 0 = never.
    task automatic do_op(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int k);
        int  n;
        bit  to;
        int  stall_cnt;
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        ALUOut    = addr;
        ReadValue = wdata;
        mem_ack   = 1'b0;
        #1;
        if (!(rd | wr)) begin
            check("nomem_stall", {15'd0, stall}, 16'd0);
            check("nomem_req", {15'd0, mem_req}, 16'd0);
            return;
        end
        check("issue_stall", {15'd0, stall}, 16'd1);
        check("issue_req", {15'd0, mem_req}, 16'd0);
        to        = !(k >= 1 && k <= T);
        n         = to ? T : k;
        stall_cnt = 1;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            // upstream values wander; the request must not follow them
            ALUOut    = 16'($urandom);
            ReadValue = 16'($urandom);
            mem_ack   = (c == k);
            mem_rdata = (c == k) ? rdata : 16'($urandom);
            #1;
            if (stall) stall_cnt++;
            check("req_req", {15'd0, mem_req}, 16'd1);
            check("req_we", {15'd0, mem_we}, {15'd0, wr});
            check("req_addr", mem_addr, addr);
            if (wr) check("req_wdata", mem_wdata, wdata);
            check("req_valid", {15'd0, mem_valid}, 16'd0);
        end
        if (!to && rd && !wr) exp_data = rdata;
        if (to) exp_err = 1'b1;
        @(negedge clk);
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1;
        check("done_valid", {15'd0, mem_valid}, 16'd1);
        check("done_stall", {15'd0, stall}, 16'd0);
        check("done_req", {15'd0, mem_req}, 16'd0);
        check("done_data", mem_data_out, exp_data);
        check("done_err", {15'd0, err}, {15'd0, exp_err});
        check("stall_cycles", 16'(stall_cnt), 16'(n + 1));
    endtask

    task automatic check_reset_values();
        check("rst_req", {15'd0, mem_req}, 16'd0);
        check("rst_stall", {15'd0, stall}, 16'd0);
        check("rst_valid", {15'd0, mem_valid}, 16'd0);
        check("rst_we", {15'd0, mem_we}, 16'd0);
        check("rst_err", {15'd0, err}, 16'd0);
        check("rst_addr", mem_addr, 16'd0);
        check("rst_wdata", mem_wdata, 16'd0);
        check("rst_data", mem_data_out, 16'd0);
    endtask

    initial begin
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        ALUOut = 16'd0; ReadValue = 16'd0; mem_rdata = 16'd0; mem_ack = 1'b0;
        exp_data = 16'd0; exp_err = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // directed: load with ack in 3rd REQ cycle
        do_op(1'b1, 1'b0, 16'h0040, 16'h5555, 16'hBEEF, 3);
        // directed: store acked at once
        do_op(1'b0, 1'b1, 16'h0010, 16'h1234, 16'hDEAD, 1);
        // back-to-back loads
        do_op(1'b1, 1'b0, 16'h0001, 16'h0000, 16'h00AA, 1);
        do_op(1'b1, 1'b0, 16'h0002, 16'h0000, 16'h00BB, 1);
        // both flags set behaves as a write
        do_op(1'b1, 1'b1, 16'h0777, 16'hCAFE, 16'h9999, 2);
        // non-memory stream with stray acks
        idle_cycles(10, 1'b1);
        // timeout on a load
        do_op(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hF00D, 0);
        idle_cycles(2, 1'b0);
        check("err_sticky", {15'd0, err}, 16'd1);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), int'($urandom_range(0, T + 2)));
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), 1'b1);
        end

        // reset in 2nd REQ cycle of a store
        @(negedge clk);
        MemWrite = 1'b1; ALUOut = 16'h0ABC; ReadValue = 16'h4321; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_rst_req", {15'd0, mem_req}, 16'd1);
        #1;
        rst = 1'b1; MemWrite = 1'b0;
        #1;
        exp_data = 16'd0; exp_err = 1'b0;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b1, 1'b0, 16'h0055, 16'h0000, 16'h7E7E, 2);

        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end

endmodule
